// File: rtl/frame_fifo.sv
`default_nettype none
// ============================================================================
// Module   : frame_fifo
// Purpose  : Store-and-forward frame buffer. Frames are written into a
//            circular RAM and only become visible to the egress AXIS port
//            once their tlast word is written without an abort. Aborted
//            frames are rolled back. Also produces the almost_full hint.
// Options  : FRAME_FIFO_STATS_EN - enables the committed/dropped counters;
//            when undefined both count outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module frame_fifo #(
    parameter int DEPTH_LOG2 = 11,
    parameter int AF_MARGIN  = 800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ingress_pkt_tvalid,
    input  logic [15:0] ingress_pkt_tdata,
    input  logic        ingress_pkt_tlast,
    input  logic        drop_current,
    input  logic        incomplete_frame,
    output logic        almost_full,
    output logic        egress_source_tvalid,
    output logic [15:0] egress_source_tdata,
    output logic        egress_source_tlast,
    input  logic        egress_sink_tready,
    output logic [15:0] frames_committed,
    output logic [15:0] frames_dropped
);

    localparam int                    c_depth   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] c_ptr_one = 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FILL    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    // Word storage: {tlast, tdata}; contents are not reset.
    logic [16:0] mem [c_depth];

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] commit_ptr_q, commit_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic                  rd_pending_q, rd_pending_d;
    logic [16:0]           ram_rdata_q, ram_rdata_d;
    logic                  out_valid_q, out_valid_d;
    logic [16:0]           out_word_q, out_word_d;
    logic                  almost_full_q, almost_full_d;

    logic [DEPTH_LOG2-1:0] wr_ptr_inc;
    logic                  full;
    logic                  abort;
    logic                  wr_en;
    logic                  drop_evt;
    logic                  commit_evt;
    logic                  out_ready;
    logic                  rd_issue;
    logic [DEPTH_LOG2-1:0] ptr_diff;
    logic [31:0]           free_words;

    assign wr_ptr_inc = wr_ptr_q + c_ptr_one;
    // One slot always stays empty so full and empty are distinguishable.
    assign full       = (wr_ptr_inc == rd_ptr_q);
    // A full FIFO only aborts the frame when a word actually needs a slot.
    assign abort      = drop_current | incomplete_frame | (ingress_pkt_tvalid & full);

    // Writer FSM: append words, commit on a clean tlast, roll back on abort.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        wr_en        = 1'b0;
        drop_evt     = 1'b0;
        commit_evt   = 1'b0;
        case (state_q)
            S_IDLE, S_FILL: begin
                // An abort in IDLE only matters when it arrives with a word.
                if (abort && (state_q == S_FILL || ingress_pkt_tvalid)) begin
                    wr_ptr_d = commit_ptr_q;
                    drop_evt = 1'b1;
                    // A truncated header means upstream already ended the
                    // frame; a tlast word also ends it. Otherwise swallow
                    // the rest of the frame.
                    if ((ingress_pkt_tvalid && ingress_pkt_tlast) || incomplete_frame) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DISCARD;
                    end
                end else if (ingress_pkt_tvalid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_inc;
                    if (ingress_pkt_tlast) begin
                        commit_ptr_d = wr_ptr_inc;
                        commit_evt   = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_DISCARD: begin
                if (ingress_pkt_tvalid && ingress_pkt_tlast) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Reader: two-stage pipe (RAM read register, then AXIS output register);
    // reads are issued only when the output register will be free to take
    // the word that is already in flight.
    always_comb begin
        out_ready    = !out_valid_q || egress_sink_tready;
        rd_issue     = (rd_ptr_q != commit_ptr_q) && out_ready;
        rd_ptr_d     = rd_issue ? (rd_ptr_q + c_ptr_one) : rd_ptr_q;
        ram_rdata_d  = rd_issue ? mem[rd_ptr_q] : ram_rdata_q;
        rd_pending_d = rd_issue || (rd_pending_q && !out_ready);
        out_valid_d  = out_valid_q;
        out_word_d   = out_word_q;
        if (out_ready) begin
            out_valid_d = rd_pending_q;
            if (rd_pending_q) begin
                out_word_d = ram_rdata_q;
            end
        end
    end

    // Backpressure hint: uncommitted words count as used space.
    always_comb begin
        ptr_diff      = wr_ptr_q - rd_ptr_q;
        free_words    = 32'(c_depth - 1) - 32'(ptr_diff);
        almost_full_d = (free_words < 32'(AF_MARGIN));
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            commit_ptr_q  <= '0;
            rd_ptr_q      <= '0;
            rd_pending_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            out_word_q    <= '0;
            almost_full_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            commit_ptr_q  <= commit_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            rd_pending_q  <= rd_pending_d;
            out_valid_q   <= out_valid_d;
            out_word_q    <= out_word_d;
            almost_full_q <= almost_full_d;
        end
    end

    // RAM read register; qualified by rd_pending_q so it needs no reset.
    always_ff @(posedge clk) begin
        ram_rdata_q <= ram_rdata_d;
    end

    // RAM write port.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_ptr_q] <= {ingress_pkt_tlast, ingress_pkt_tdata};
        end
    end

    assign almost_full          = almost_full_q;
    assign egress_source_tvalid = out_valid_q;
    assign egress_source_tdata  = out_word_q[15:0];
    assign egress_source_tlast  = out_word_q[16];

`ifdef FRAME_FIFO_STATS_EN
    logic [15:0] frames_committed_q, frames_committed_d;
    logic [15:0] frames_dropped_q, frames_dropped_d;

    // Saturating frame counters.
    always_comb begin
        frames_committed_d = frames_committed_q;
        frames_dropped_d   = frames_dropped_q;
        if (commit_evt && frames_committed_q != 16'hFFFF) begin
            frames_committed_d = frames_committed_q + 16'd1;
        end
        if (drop_evt && frames_dropped_q != 16'hFFFF) begin
            frames_dropped_d = frames_dropped_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            frames_committed_q <= '0;
            frames_dropped_q   <= '0;
        end else begin
            frames_committed_q <= frames_committed_d;
            frames_dropped_q   <= frames_dropped_d;
        end
    end

    assign frames_committed = frames_committed_q;
    assign frames_dropped   = frames_dropped_q;
`else
    logic unused_stats_evt;
    assign unused_stats_evt = commit_evt ^ drop_evt;
    assign frames_committed = 16'd0;
    assign frames_dropped   = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_frame_fifo
// Purpose  : Scoreboard bench for frame_fifo. A large instance (default
//            parameters) and a small one (DEPTH_LOG2=6, AF_MARGIN=16) share
//            the ingress stimulus, gated by sel_small.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_fifo;

`ifdef FRAME_FIFO_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        sel_small;
    logic        in_valid, in_last, in_drop, in_inc;
    logic [15:0] in_data;
    logic        tready;
    logic        rand_rdy;

    logic        b_af, b_tv, b_tl;
    logic [15:0] b_td, b_fc, b_fd;
    logic        s_af, s_tv, s_tl;
    logic [15:0] s_td, s_fc, s_fd;

    logic        e_af, e_tv, e_tl;
    logic [15:0] e_td, e_fc, e_fd;

    assign e_af = sel_small ? s_af : b_af;
    assign e_tv = sel_small ? s_tv : b_tv;
    assign e_tl = sel_small ? s_tl : b_tl;
    assign e_td = sel_small ? s_td : b_td;
    assign e_fc = sel_small ? s_fc : b_fc;
    assign e_fd = sel_small ? s_fd : b_fd;

    frame_fifo dut_b (
        .clk                  (clk),
        .reset                (reset),
        .ingress_pkt_tvalid   (in_valid & ~sel_small),
        .ingress_pkt_tdata    (in_data),
        .ingress_pkt_tlast    (in_last),
        .drop_current         (in_drop & ~sel_small),
        .incomplete_frame     (in_inc & ~sel_small),
        .almost_full          (b_af),
        .egress_source_tvalid (b_tv),
        .egress_source_tdata  (b_td),
        .egress_source_tlast  (b_tl),
        .egress_sink_tready   (tready),
        .frames_committed     (b_fc),
        .frames_dropped       (b_fd)
    );

    frame_fifo #(.DEPTH_LOG2(6), .AF_MARGIN(16)) dut_s (
        .clk                  (clk),
        .reset                (reset),
        .ingress_pkt_tvalid   (in_valid & sel_small),
        .ingress_pkt_tdata    (in_data),
        .ingress_pkt_tlast    (in_last),
        .drop_current         (in_drop & sel_small),
        .incomplete_frame     (in_inc & sel_small),
        .almost_full          (s_af),
        .egress_source_tvalid (s_tv),
        .egress_source_tdata  (s_td),
        .egress_source_tlast  (s_tl),
        .egress_sink_tready   (tready),
        .frames_committed     (s_fc),
        .frames_dropped       (s_fd)
    );

    int          tests_run = 0;
    int          failed    = 0;
    int          fid       = 0;
    logic [16:0] exp_q[$];

    // Advance one clock; inputs change #1 after the edge.
    task automatic tick();
        if (rand_rdy) tready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0; in_last = 1'b0; in_drop = 1'b0; in_inc = 1'b0;
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Drive one frame. drop_at/inc_at (1-based, 0 = none) mark the abort
    // word; the frame stops after the incomplete_frame word. Words of good
    // frames go onto the scoreboard.
    task automatic send_frame(input int len, input int drop_at, input int inc_at, input bit good);
        fid++;
        if (good) begin
            for (int i = 1; i <= len; i++) exp_q.push_back({(i == len), fid[7:0], 8'(i)});
        end
        for (int i = 1; i <= len; i++) begin
            in_valid = 1'b1;
            in_data  = {fid[7:0], 8'(i)};
            in_last  = (i == len);
            in_drop  = (i == drop_at);
            in_inc   = (i == inc_at);
            tick();
            in_valid = 1'b0; in_last = 1'b0; in_drop = 1'b0; in_inc = 1'b0;
            if (i == inc_at) break;
        end
    endtask

    task automatic wait_drain(input int maxc, input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || e_tv === 1'b1) && n < maxc) begin
            tick();
            n++;
        end
        tests_run++;
        if (exp_q.size() != 0 || e_tv === 1'b1) begin
            failed++;
            $display("FAIL %s_drain: %0d words still expected, tvalid=%b after %0d cycles, required 0 words and tvalid=0",
                     name, exp_q.size(), e_tv, maxc);
        end
    endtask

    // Egress monitor: scoreboard pop on each handshake plus AXIS hold rule.
    task automatic monitor();
        logic        pv, pr, pl;
        logic [15:0] pd;
        logic [16:0] exp;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    tests_run++;
                    if (e_tv !== 1'b1 || e_td !== pd || e_tl !== pl) begin
                        failed++;
                        $display("FAIL axis_hold: tvalid=%b tdata=%h tlast=%b, required 1 %h %b",
                                 e_tv, e_td, e_tl, pd, pl);
                    end
                end
                if (e_tv === 1'b1 && tready === 1'b1) begin
                    tests_run++;
                    if (exp_q.size() == 0) begin
                        failed++;
                        $display("FAIL egress_unexpected: got tdata=%h tlast=%b, required no word", e_td, e_tl);
                    end else begin
                        exp = exp_q.pop_front();
                        if ({e_tl, e_td} !== exp) begin
                            failed++;
                            $display("FAIL egress_word: got tlast=%b tdata=%h, required tlast=%b tdata=%h",
                                     e_tl, e_td, exp[16], exp[15:0]);
                        end
                    end
                end
                pv = e_tv; pr = tready; pd = e_td; pl = e_tl;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({b_tv, b_tl, b_td, b_af, b_fc, b_fd} !== 50'd0) begin
            failed++;
            $display("FAIL reset_big: tv=%b tl=%b td=%h af=%b fc=%0d fd=%0d, required all 0",
                     b_tv, b_tl, b_td, b_af, b_fc, b_fd);
        end
        tests_run++;
        if ({s_tv, s_tl, s_td, s_af, s_fc, s_fd} !== 50'd0) begin
            failed++;
            $display("FAIL reset_small: tv=%b tl=%b td=%h af=%b fc=%0d fd=%0d, required all 0",
                     s_tv, s_tl, s_td, s_af, s_fc, s_fd);
        end
        // Stall a committed frame at the output, leave another half written,
        // then reset: the held word and the partial frame must both vanish.
        tready = 1'b0;
        send_frame(5, 0, 0, 1);
        fid++;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_data = {fid[7:0], 8'(i)}; in_last = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        tests_run++;
        if (e_tv !== 1'b1) begin
            failed++;
            $display("FAIL pre_reset_hold: tvalid=%b, required 1", e_tv);
        end
        do_reset();
        tests_run++;
        if ({e_tv, e_tl, e_td} !== 18'd0) begin
            failed++;
            $display("FAIL midreset_out: tv=%b tl=%b td=%h, required 0 0 0000", e_tv, e_tl, e_td);
        end
        tready = 1'b1;
        send_frame(4, 0, 0, 1);
        wait_drain(50, "post_reset");
    endtask

    task automatic test_single_frame();
        logic [15:0] first;
        do_reset();
        tready = 1'b1;
        send_frame(32, 0, 0, 1);
        first = {fid[7:0], 8'd1};
        // tlast sampled at edge N; egress valid expected at N+2.
        tests_run++;
        if (e_tv !== 1'b0) begin
            failed++;
            $display("FAIL latency_n: tvalid=%b at tlast edge, required 0", e_tv);
        end
        tick();
        tests_run++;
        if (e_tv !== 1'b0) begin
            failed++;
            $display("FAIL latency_n1: tvalid=%b at N+1, required 0", e_tv);
        end
        tick();
        tests_run++;
        if (e_tv !== 1'b1 || e_td !== first || e_tl !== 1'b0) begin
            failed++;
            $display("FAIL latency_n2: tvalid=%b tdata=%h tlast=%b at N+2, required 1 %h 0",
                     e_tv, e_td, e_tl, first);
        end
        wait_drain(100, "single");
        tests_run++;
        if (e_fc !== 16'(STATS)) begin
            failed++;
            $display("FAIL single_committed: got %0d, required %0d", e_fc, STATS);
        end
    endtask

    task automatic test_drop();
        do_reset();
        tready = 1'b1;
        send_frame(20, 0, 0, 1);
        send_frame(40, 10, 0, 0);
        tests_run++;
        if (dut_b.wr_ptr_q !== 11'd20) begin
            failed++;
            $display("FAIL drop_rollback: wr_ptr=%0d, required 20", dut_b.wr_ptr_q);
        end
        send_frame(20, 0, 0, 1);
        wait_drain(200, "drop");
        tests_run++;
        if (e_fd !== 16'(STATS)) begin
            failed++;
            $display("FAIL drop_count: got %0d, required %0d", e_fd, STATS);
        end
    endtask

    task automatic test_incomplete();
        do_reset();
        tready = 1'b1;
        send_frame(10, 0, 4, 0);
        send_frame(12, 0, 0, 1);
        wait_drain(100, "incomplete");
        tests_run++;
        if (e_fd !== 16'(STATS)) begin
            failed++;
            $display("FAIL incomplete_count: got %0d, required %0d", e_fd, STATS);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        tready = 1'b1;
        send_frame(1, 1, 0, 0);   // drop on a single-word frame in IDLE
        send_frame(6, 6, 0, 0);   // drop together with tlast
        send_frame(5, 1, 0, 0);   // drop on first word, rest discarded
        send_frame(3, 0, 0, 1);
        send_frame(1, 0, 0, 1);   // single-word frame
        wait_drain(100, "simultaneous");
        tests_run++;
        if (e_fd !== 16'(3 * STATS) || e_fc !== 16'(2 * STATS)) begin
            failed++;
            $display("FAIL simul_counts: dropped=%0d committed=%0d, required %0d %0d",
                     e_fd, e_fc, 3 * STATS, 2 * STATS);
        end
    endtask

    task automatic test_random_ready();
        do_reset();
        rand_rdy = 1'b1;
        for (int f = 0; f < 100; f++) begin
            send_frame($urandom_range(1, 24), 0, 0, 1);
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_drain(6000, "random");
        rand_rdy = 1'b0;
        tready   = 1'b1;
        tests_run++;
        if (e_fc !== 16'(100 * STATS)) begin
            failed++;
            $display("FAIL random_committed: got %0d, required %0d", e_fc, 100 * STATS);
        end
    endtask

    task automatic test_full_abort();
        sel_small = 1'b1;
        do_reset();
        tready = 1'b0;
        send_frame(70, 0, 0, 0);
        tests_run++;
        if (e_fd !== 16'(STATS) || e_tv !== 1'b0 || dut_s.wr_ptr_q !== 6'd0) begin
            failed++;
            $display("FAIL full_abort: dropped=%0d tvalid=%b wr_ptr=%0d, required %0d 0 0",
                     e_fd, e_tv, dut_s.wr_ptr_q, STATS);
        end
        tready = 1'b1;
        send_frame(10, 0, 0, 1);
        wait_drain(50, "after_full");
    endtask

    task automatic test_almost_full();
        do_reset();
        tready = 1'b0;
        fid++;
        for (int i = 1; i <= 50; i++) exp_q.push_back({(i == 50), fid[7:0], 8'(i)});
        for (int i = 1; i <= 50; i++) begin
            in_valid = 1'b1; in_data = {fid[7:0], 8'(i)}; in_last = (i == 50);
            tick();
            in_valid = 1'b0; in_last = 1'b0;
            if (i == 47 || i == 48) begin
                tick();
                tests_run++;
                if (e_af !== (i == 48)) begin
                    failed++;
                    $display("FAIL af_fill_%0d: almost_full=%b, required %b", i, e_af, (i == 48));
                end
            end
        end
        // Two words move into the egress pipe; 48 stay in RAM (15 free).
        repeat (4) tick();
        tests_run++;
        if (e_af !== 1'b1 || e_tv !== 1'b1) begin
            failed++;
            $display("FAIL af_48: almost_full=%b tvalid=%b, required 1 1", e_af, e_tv);
        end
        tready = 1'b1;
        tick();
        tready = 1'b0;
        tests_run++;
        if (e_af !== 1'b1) begin
            failed++;
            $display("FAIL af_lag: almost_full=%b at drain edge, required 1", e_af);
        end
        tick();
        tests_run++;
        if (e_af !== 1'b0) begin
            failed++;
            $display("FAIL af_release: almost_full=%b one edge after drain, required 0", e_af);
        end
        tready = 1'b1;
        wait_drain(200, "af");
    endtask

    initial begin
        reset = 1'b1; sel_small = 1'b0; rand_rdy = 1'b0; tready = 1'b1;
        in_valid = 1'b0; in_last = 1'b0; in_drop = 1'b0; in_inc = 1'b0; in_data = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_single_frame();
        test_drop();
        test_incomplete();
        test_simultaneous();
        test_random_ready();
        test_full_abort();
        test_almost_full();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish within 2 ms, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
